// File: rtl/alu_rr_scheduler_if.sv
// Bundles the two requester handshakes, the shared ALU bus and the response
// channel so the scheduler and its environment connect through one port.
interface alu_rr_scheduler_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic [1:0] req0_op;
  logic       req1_valid;
  logic       req1_ready;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic [1:0] req1_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_op;
  logic [3:0] alu_res;
  logic       alu_cout;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [3:0] rsp_res;
  logic       rsp_cout;
  logic       rsp_mismatch;
  logic [7:0] mismatch_cnt;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output alu_a, alu_b, alu_op,
    input  alu_res, alu_cout,
    output rsp_valid, rsp_id, rsp_res, rsp_cout, rsp_mismatch, mismatch_cnt,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  alu_a, alu_b, alu_op,
    output alu_res, alu_cout,
    input  rsp_valid, rsp_id, rsp_res, rsp_cout, rsp_mismatch, mismatch_cnt,
    output rsp_ready
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin sharing of one external 4-bit ALU between two requesters, with
// a golden-model cross-check that counts results the ALU got wrong.
module alu_rr_scheduler #(
  parameter int unsigned SETTLE   = 1,
  parameter bit          CHECK_EN = 1'b1
) (
  input logic               clk,
  input logic               rst,
  alu_rr_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_e;

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  state_e     state_q, state_d;
  logic       lastGrant_q, lastGrant_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] aluA_q, aluA_d;
  logic [3:0] aluB_q, aluB_d;
  logic [1:0] aluOp_q, aluOp_d;
  logic       rspValid_q, rspValid_d;
  logic       rspId_q, rspId_d;
  logic [3:0] rspRes_q, rspRes_d;
  logic       rspCout_q, rspCout_d;
  logic       rspMis_q, rspMis_d;
  logic [7:0] misCnt_q, misCnt_d;

  logic       grant0, grant1;
  logic [4:0] golden;
  logic       mismatch;

  // On a tie the requester that did not win last time gets the ALU.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | lastGrant_q);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ~lastGrant_q);

  assign bus.req0_ready = (state_q == IDLE) & grant0;
  assign bus.req1_ready = (state_q == IDLE) & grant1;

  always_comb begin
    golden = 5'd0;
    case (aluOp_q)
      2'b00:   golden = {1'b0, aluA_q} + {1'b0, aluB_q};
      2'b01:   golden = {1'b0, aluA_q} - {1'b0, aluB_q};
      2'b10:   golden = {1'b0, aluA_q & aluB_q};
      default: golden = {1'b0, aluA_q | aluB_q};
    endcase
  end

  assign mismatch = CHECK_EN & ({bus.alu_cout, bus.alu_res} != golden);

  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    cnt_d       = cnt_q;
    aluA_d      = aluA_q;
    aluB_d      = aluB_q;
    aluOp_d     = aluOp_q;
    rspValid_d  = rspValid_q;
    rspId_d     = rspId_q;
    rspRes_d    = rspRes_q;
    rspCout_d   = rspCout_q;
    rspMis_d    = rspMis_q;
    misCnt_d    = misCnt_q;
    case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          aluA_d      = grant1 ? bus.req1_a  : bus.req0_a;
          aluB_d      = grant1 ? bus.req1_b  : bus.req0_b;
          aluOp_d     = grant1 ? bus.req1_op : bus.req0_op;
          lastGrant_d = grant1;
          rspId_d     = grant1;
          cnt_d       = SETTLE_L;
          state_d     = DRIVE;
        end
      end
      DRIVE: begin
        // The ALU has settled once the counter reaches its last cycle.
        if (cnt_q == 4'd1) begin
          rspRes_d   = bus.alu_res;
          rspCout_d  = bus.alu_cout;
          rspMis_d   = mismatch;
          rspValid_d = 1'b1;
          cnt_d      = 4'd0;
          state_d    = RESP;
          if (mismatch && (misCnt_q != 8'hFF)) begin
            misCnt_d = misCnt_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rspValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      cnt_q       <= 4'd0;
      aluA_q      <= 4'd0;
      aluB_q      <= 4'd0;
      aluOp_q     <= 2'd0;
      rspValid_q  <= 1'b0;
      rspId_q     <= 1'b0;
      rspRes_q    <= 4'd0;
      rspCout_q   <= 1'b0;
      rspMis_q    <= 1'b0;
      misCnt_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      cnt_q       <= cnt_d;
      aluA_q      <= aluA_d;
      aluB_q      <= aluB_d;
      aluOp_q     <= aluOp_d;
      rspValid_q  <= rspValid_d;
      rspId_q     <= rspId_d;
      rspRes_q    <= rspRes_d;
      rspCout_q   <= rspCout_d;
      rspMis_q    <= rspMis_d;
      misCnt_q    <= misCnt_d;
    end
  end

  assign bus.alu_a        = aluA_q;
  assign bus.alu_b        = aluB_q;
  assign bus.alu_op       = aluOp_q;
  assign bus.rsp_valid    = rspValid_q;
  assign bus.rsp_id       = rspId_q;
  assign bus.rsp_res      = rspRes_q;
  assign bus.rsp_cout     = rspCout_q;
  assign bus.rsp_mismatch = rspMis_q;
  assign bus.mismatch_cnt = misCnt_q;

endmodule
